alu_op_issuer: RTL and testbench
================================

Name: alu_op_issuer

Overview:
Bus-side initiator for the ALU_DESIGN operand interface. It accepts operation requests over a valid/ready port and buffers them in a small FIFO. It drives OPA/OPB/CMD/MODE/CIN/CE/INP_VALID into the ALU, including split two-phase operand delivery. It waits out the ALU result latency, captures RES and flags, and returns them on a valid/ready response port. It replaces the testbench driver in system integration.

Parameters:
DW, 8, operand width (matches ALU `width`)
CW, 4, command width (matches ALU `cwidth`)
DEPTH, 4, request FIFO entries (power of 2, >=2)
LAT, 1, ALU result latency in cycles after the final operand cycle
MUL_LAT, 2, result latency for MODE=1 with CMD 9 or 10

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO not full
req_opa  in  DW  operand A
req_opb  in  DW  operand B
req_cmd  in  CW  ALU command
req_mode  in  1  1=arithmetic, 0=logical
req_cin  in  1  carry-in
req_split  in  1  1=deliver A then B on separate cycles
OPA  out  DW  to ALU
OPB  out  DW  to ALU
CMD  out  CW  to ALU
MODE  out  1  to ALU
CIN  out  1  to ALU
CE  out  1  ALU clock enable
INP_VALID  out  2  operand-valid code to ALU
RES  in  2*DW  ALU result
COUT, OFLOW, ERR, E, G, L  in  1 each  ALU flags
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts
rsp_res  out  2*DW  captured RES
rsp_flags  out  6  {COUT,OFLOW,ERR,E,G,L}

Behaviour:
- Reset (async, RST=1): FIFO empty; state IDLE; OPA/OPB/CMD/MODE/CIN/CE/INP_VALID/rsp_valid/rsp_res/rsp_flags = 0. req_ready = !full, so it reads 1 while reset is asserted. Reset deasserts synchronously to CLK internally.
- Push on req_valid&&req_ready. Push is ignored when full. Push and pop in the same cycle are legal when not full. A push while full is not accepted; req_ready rises the cycle after a pop.
- FSM states: IDLE, ISSUE_A, ISSUE_B, WAIT, HOLD.
- IDLE: if FIFO non-empty, pop the head into the op register and go to ISSUE_A. Otherwise CE=0 and INP_VALID=00.
- ISSUE_A: CE=1; drive OPA, CMD, MODE, CIN.
  - Split op: INP_VALID=01, OPB=0, next state ISSUE_B.
  - Non-split op: INP_VALID=11 with OPB, next state WAIT.
- ISSUE_B: CE=1, INP_VALID=10, OPB driven, OPA/CMD/MODE held; next state WAIT.
- WAIT: CE=1, INP_VALID=00, operands held. The down-counter loads L-1, where L=MUL_LAT if MODE=1 and CMD in {9,10}, else L=LAT.
  - When the counter reaches 0, sample RES and the flags into the rsp registers, set rsp_valid=1, and go to HOLD.
  - With LAT=1, capture occurs on the first WAIT cycle, i.e. one clock after the final operand cycle.
- HOLD: CE=0, INP_VALID=00. rsp_* stay stable while rsp_valid&&!rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE. The next op's ISSUE_A follows one cycle later.
- Only one op is in flight. Requests keep buffering during WAIT and HOLD.
- ERR=1 is passed through in rsp_flags unchanged; there is no retry.
- Reset mid-operation: the in-flight op and all FIFO contents are dropped; no response is produced.

Decomposition:
- alu_issuer_pkg holds:
  - the state enum;
  - INP_VALID code constants (IV_NONE=00, IV_A=01, IV_B=10, IV_AB=11);
  - CMD_MUL_INC=9 and CMD_MUL_SHL=10;
  - a packed alu_req_t struct {opa,opb,cmd,mode,cin,split}.
- Sub-module alu_req_fifo: synchronous FIFO of alu_req_t, DEPTH entries, with full/empty and an extra-bit pointer wrap.

Test Plan:
- ADD, non-split: opa=10, opb=20, cmd=0, mode=1 -> one cycle INP_VALID=11, CE=1; capture two clocks after issue; rsp_res=30, flags COUT=0.
- Split ADD: opa=200, opb=100, split=1 -> INP_VALID 01 then 10 on consecutive cycles; rsp_res=300 (COUT=1 when RES width DW+1 semantics are applied).
- Multiply, cmd=9, mode=1, opa=3, opb=4 -> capture exactly MUL_LAT cycles after the final operand cycle; rsp_res=20.
- Backpressure: push 5 requests with rsp_ready=0 -> req_ready drops after 4 are buffered; rsp_* stays stable in HOLD; all responses arrive in order once rsp_ready=1.
- Reset asserted during WAIT -> all outputs go to 0 immediately (async); no rsp_valid afterwards; FIFO is empty.
- Compare with mode=0, cmd=8, opa=5, opb=5 -> rsp_flags E=1, G=0, L=0.

Source files
------------

// File: rtl/alu_issuer_pkg.sv
// Shared types and constants for the ALU operand issuer: FSM states,
// INP_VALID codes, multiply command codes and the buffered request record.
package alu_issuer_pkg;

    localparam int ALU_DW = 8;
    localparam int ALU_CW = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B,
        WAIT,
        HOLD
    } issuer_state_t;

    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;

    localparam logic [ALU_CW-1:0] CMD_MUL_INC = 4'd9;
    localparam logic [ALU_CW-1:0] CMD_MUL_SHL = 4'd10;

    typedef struct packed {
        logic [ALU_DW-1:0] opa;
        logic [ALU_DW-1:0] opb;
        logic [ALU_CW-1:0] cmd;
        logic              mode;
        logic              cin;
        logic              split;
    } alu_req_t;

    // Multiplies in arithmetic mode take the longer result latency.
    function automatic logic is_mul(input logic mode, input logic [ALU_CW-1:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request buffer for the issuer: DEPTH-entry synchronous FIFO of alu_req_t
// using pointers with one extra wrap bit to tell full from empty.
module alu_req_fifo
    import alu_issuer_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic     CLK,
    input  logic     RST,
    input  logic     push,
    input  alu_req_t wdata,
    input  logic     pop,
    output alu_req_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    alu_req_t    mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; only pointer-qualified entries are ever read.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Bus-side initiator for the ALU operand interface: buffers requests, issues
// one op at a time (optionally split A/B), waits out latency, returns result.
module alu_op_issuer
    import alu_issuer_pkg::*;
#(
    parameter int DW      = ALU_DW,
    parameter int CW      = ALU_CW,
    parameter int DEPTH   = 4,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2
)(
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [DW-1:0]   req_opa,
    input  logic [DW-1:0]   req_opb,
    input  logic [CW-1:0]   req_cmd,
    input  logic            req_mode,
    input  logic            req_cin,
    input  logic            req_split,
    output logic [DW-1:0]   OPA,
    output logic [DW-1:0]   OPB,
    output logic [CW-1:0]   CMD,
    output logic            MODE,
    output logic            CIN,
    output logic            CE,
    output logic [1:0]      INP_VALID,
    input  logic [2*DW-1:0] RES,
    input  logic            COUT,
    input  logic            OFLOW,
    input  logic            ERR,
    input  logic            E,
    input  logic            G,
    input  logic            L,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_res,
    output logic [5:0]      rsp_flags
);

    localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // RST asserts immediately but releases only on a clock edge.
    logic rst_meta;
    logic rst_int;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rst_meta <= 1'b1;
            rst_int  <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_int  <= rst_meta;
        end
    end

    alu_req_t      req_in;
    alu_req_t      fifo_head;
    alu_req_t      op_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          capture;
    logic [CNT_W-1:0] cnt_q;
    issuer_state_t state_q;
    issuer_state_t state_d;

    assign req_in = '{opa: req_opa, opb: req_opb, cmd: req_cmd,
                      mode: req_mode, cin: req_cin, split: req_split};
    assign req_ready = !fifo_full;

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (rst_int),
        .push  (req_valid),
        .wdata (req_in),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign OPA  = op_q.opa;
    assign CMD  = op_q.cmd;
    assign MODE = op_q.mode;
    assign CIN  = op_q.cin;

    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        capture   = 1'b0;
        CE        = 1'b0;
        INP_VALID = IV_NONE;
        OPB       = op_q.opb;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE_A;
                end
            end
            ISSUE_A: begin
                CE = 1'b1;
                if (op_q.split) begin
                    INP_VALID = IV_A;
                    OPB       = '0;
                    state_d   = ISSUE_B;
                end else begin
                    INP_VALID = IV_AB;
                    state_d   = WAIT;
                end
            end
            ISSUE_B: begin
                CE        = 1'b1;
                INP_VALID = IV_B;
                state_d   = WAIT;
            end
            WAIT: begin
                CE = 1'b1;
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst_int) begin
        if (rst_int) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_flags <= '0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) op_q <= fifo_head;
            // Latency counter is armed on entry to WAIT from either issue state.
            if (state_q != WAIT && state_d == WAIT)
                cnt_q <= is_mul(op_q.mode, op_q.cmd) ? MUL_LD : LAT_LD;
            else if (state_q == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - CNT_ONE;
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_res   <= RES;
                rsp_flags <= {COUT, OFLOW, ERR, E, G, L};
            end else if (state_q == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer with a behavioural ALU that drives RES only in the
// cycle its latency allows; responses are checked against an expected queue.
module tb_alu_op_issuer;

    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int DEPTH   = 4;
    localparam int LAT     = 1;
    localparam int MUL_LAT = 2;
    localparam int RW      = 2*DW + 6;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [DW-1:0]   req_opa = '0;
    logic [DW-1:0]   req_opb = '0;
    logic [CW-1:0]   req_cmd = '0;
    logic            req_mode = 1'b0;
    logic            req_cin = 1'b0;
    logic            req_split = 1'b0;
    logic [DW-1:0]   OPA;
    logic [DW-1:0]   OPB;
    logic [CW-1:0]   CMD;
    logic            MODE;
    logic            CIN;
    logic            CE;
    logic [1:0]      INP_VALID;
    logic [2*DW-1:0] RES = '0;
    logic            COUT = 1'b0;
    logic            OFLOW = 1'b0;
    logic            ERR = 1'b0;
    logic            E = 1'b0;
    logic            G = 1'b0;
    logic            L = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [2*DW-1:0] rsp_res;
    logic [5:0]      rsp_flags;

    logic [RW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    alu_op_issuer #(
        .DW(DW), .CW(CW), .DEPTH(DEPTH), .LAT(LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
        .req_mode(req_mode), .req_cin(req_cin), .req_split(req_split),
        .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN),
        .CE(CE), .INP_VALID(INP_VALID),
        .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .ERR(ERR), .E(E), .G(G), .L(L),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags)
    );

    // Reference ALU: returns {RES, COUT, OFLOW, ERR, E, G, L}.
    function automatic logic [RW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [CW-1:0] cmd, input logic mode,
                                             input logic cin);
        logic [2*DW-1:0] r;
        logic [5:0]      f;
        logic [DW-1:0]   ash;
        r   = '0;
        f   = '0;
        ash = a << 1;
        if (mode) begin
            case (cmd)
                4'd0:    begin r = 16'(a) + 16'(b) + 16'(cin); f[5] = r[DW]; end
                4'd9:    r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
                4'd10:   r = 16'(ash) * 16'(b);
                default: f[3] = 1'b1;
            endcase
        end else begin
            case (cmd)
                4'd0:    r = 16'(a & b);
                4'd8:    begin f[2] = (a == b); f[1] = (a > b); f[0] = (a < b); end
                default: f[3] = 1'b1;
            endcase
        end
        return {r, f};
    endfunction

    logic [DW-1:0] a_lat = '0;
    logic [RW-1:0] alu_pend = '0;
    int            alu_cnt = 0;

    // Behavioural ALU: result bus is garbage except in its valid cycle.
    always @(posedge CLK) begin
        {RES, COUT, OFLOW, ERR, E, G, L} <= {16'hDEAD, 6'b010101};
        if (alu_cnt != 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) {RES, COUT, OFLOW, ERR, E, G, L} <= alu_pend;
        end
        if (CE && INP_VALID == 2'b01) a_lat <= OPA;
        if (CE && (INP_VALID == 2'b11 || INP_VALID == 2'b10)) begin
            if (MODE && (CMD == 4'd9 || CMD == 4'd10)) begin
                alu_pend <= alu_fn((INP_VALID == 2'b11) ? OPA : a_lat, OPB, CMD, MODE, CIN);
                alu_cnt  <= MUL_LAT - 1;
            end else begin
                {RES, COUT, OFLOW, ERR, E, G, L} <=
                    alu_fn((INP_VALID == 2'b11) ? OPA : a_lat, OPB, CMD, MODE, CIN);
            end
        end
    end

    // Driver: called at a negedge, returns at a negedge after the accepting edge.
    task automatic push_req(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [CW-1:0] cmd, input logic mode,
                            input logic cin, input logic split, output bit accepted);
        req_opa = a; req_opb = b; req_cmd = cmd;
        req_mode = mode; req_cin = cin; req_split = split;
        req_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 30 && !accepted; i++) begin
            if (req_ready) accepted = 1'b1;
            @(negedge CLK);
        end
        req_valid = 1'b0;
        if (accepted) exp_q.push_back(alu_fn(a, b, cmd, mode, cin));
    endtask

    // Waits (bounded) for a response handshake and returns its payload.
    task automatic wait_rsp(output logic [RW-1:0] got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rsp_valid && rsp_ready) begin
                ok  = 1'b1;
                got = {rsp_res, rsp_flags};
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({OPA, OPB, CMD, MODE, CIN, CE, INP_VALID} !== '0)
            $display("FAIL reset_alu_side: got %h required 0", {OPA, OPB, CMD, MODE, CIN, CE, INP_VALID});
        else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_res, rsp_flags} !== '0)
            $display("FAIL reset_rsp_side: got %h required 0", {rsp_valid, rsp_res, rsp_flags});
        else n_pass++;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b required 1", req_ready);
        else n_pass++;
        RST = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_add();
        bit acc;
        rsp_ready = 1'b1;
        push_req(8'd10, 8'd20, 4'd0, 1'b1, 1'b0, 1'b0, acc);
        @(negedge CLK);
        n_checks++;
        if ({CE, INP_VALID, OPA, OPB, CMD, MODE} !== {1'b1, 2'b11, 8'd10, 8'd20, 4'd0, 1'b1})
            $display("FAIL add_issue: got %h required %h", {CE, INP_VALID, OPA, OPB, CMD, MODE},
                     {1'b1, 2'b11, 8'd10, 8'd20, 4'd0, 1'b1});
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if ({CE, INP_VALID, rsp_valid} !== {1'b1, 2'b00, 1'b0})
            $display("FAIL add_wait: got %b required 1000", {CE, INP_VALID, rsp_valid});
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if ({rsp_valid, rsp_res, rsp_flags, CE} !== {1'b1, 16'd30, 6'b000000, 1'b0})
            $display("FAIL add_capture: got %h required %h", {rsp_valid, rsp_res, rsp_flags, CE},
                     {1'b1, 16'd30, 6'b000000, 1'b0});
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0 || {rsp_res, rsp_flags} !== exp_q[0])
            $display("FAIL add_scoreboard: got %h required %h", {rsp_res, rsp_flags},
                     (exp_q.size() != 0) ? exp_q[0] : '0);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge CLK);
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL add_release: got %b required 0", rsp_valid);
        else n_pass++;
    endtask

    task automatic test_split();
        bit acc;
        bit ok;
        logic [RW-1:0] got;
        push_req(8'd200, 8'd100, 4'd0, 1'b1, 1'b0, 1'b1, acc);
        @(negedge CLK);
        n_checks++;
        if ({CE, INP_VALID, OPA, OPB} !== {1'b1, 2'b01, 8'd200, 8'd0})
            $display("FAIL split_phase_a: got %h required %h", {CE, INP_VALID, OPA, OPB},
                     {1'b1, 2'b01, 8'd200, 8'd0});
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if ({CE, INP_VALID, OPA, OPB} !== {1'b1, 2'b10, 8'd200, 8'd100})
            $display("FAIL split_phase_b: got %h required %h", {CE, INP_VALID, OPA, OPB},
                     {1'b1, 2'b10, 8'd200, 8'd100});
        else n_pass++;
        wait_rsp(got, ok);
        n_checks++;
        if (!ok || got !== {16'd300, 6'b100000} || exp_q.size() == 0 || got !== exp_q[0])
            $display("FAIL split_result: got %h ok=%0d required %h", got, ok, {16'd300, 6'b100000});
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic test_mul();
        bit acc;
        int cyc;
        push_req(8'd3, 8'd4, 4'd9, 1'b1, 1'b0, 1'b0, acc);
        @(negedge CLK);
        n_checks++;
        if ({CE, INP_VALID} !== 3'b111) $display("FAIL mul_issue: got %b required 111", {CE, INP_VALID});
        else n_pass++;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        n_checks++;
        if (cyc !== MUL_LAT + 1) $display("FAIL mul_latency: got %0d required %0d", cyc, MUL_LAT + 1);
        else n_pass++;
        n_checks++;
        if ({rsp_res, rsp_flags} !== {16'd20, 6'b000000} || exp_q.size() == 0 || {rsp_res, rsp_flags} !== exp_q[0])
            $display("FAIL mul_result: got %h required %h", {rsp_res, rsp_flags}, {16'd20, 6'b000000});
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge CLK);
    endtask

    task automatic test_compare_err();
        bit acc;
        bit ok;
        logic [RW-1:0] got;
        push_req(8'd5, 8'd5, 4'd8, 1'b0, 1'b0, 1'b0, acc);
        wait_rsp(got, ok);
        n_checks++;
        if (!ok || got !== {16'd0, 6'b000100})
            $display("FAIL compare_eq: got %h ok=%0d required %h", got, ok, {16'd0, 6'b000100});
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        push_req(8'd7, 8'd9, 4'd15, 1'b1, 1'b0, 1'b0, acc);
        wait_rsp(got, ok);
        n_checks++;
        if (!ok || got !== {16'd0, 6'b001000})
            $display("FAIL err_passthrough: got %h ok=%0d required %h", got, ok, {16'd0, 6'b001000});
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic test_backpressure();
        bit acc;
        bit ok;
        int n_acc;
        int kind;
        logic [RW-1:0] got;
        logic [RW-1:0] snap;
        logic [CW-1:0] cmds [4];
        cmds[0] = 4'd0; cmds[1] = 4'd9; cmds[2] = 4'd10; cmds[3] = 4'd8;
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            kind = $urandom_range(0, 3);
            push_req(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), cmds[kind],
                     (kind != 3), 1'b0, 1'($urandom_range(0, 1)), acc);
            if (acc) n_acc++;
        end
        n_checks++;
        if (n_acc !== 5) $display("FAIL bp_accepted: got %0d required 5", n_acc);
        else n_pass++;
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL bp_full: got %b required 0", req_ready);
        else n_pass++;
        repeat (6) @(negedge CLK);
        snap = {rsp_res, rsp_flags};
        n_checks++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0 || snap !== exp_q[0])
            $display("FAIL bp_hold_value: got %h valid=%b required %h", snap, rsp_valid,
                     (exp_q.size() != 0) ? exp_q[0] : '0);
        else n_pass++;
        repeat (4) @(negedge CLK);
        n_checks++;
        if ({rsp_valid, rsp_res, rsp_flags, req_ready} !== {1'b1, snap, 1'b0})
            $display("FAIL bp_hold_stable: got %h required %h", {rsp_valid, rsp_res, rsp_flags, req_ready},
                     {1'b1, snap, 1'b0});
        else n_pass++;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(got, ok);
            n_checks++;
            if (!ok || exp_q.size() == 0 || got !== exp_q[0])
                $display("FAIL bp_order_%0d: got %h ok=%0d required %h", i, got, ok,
                         (exp_q.size() != 0) ? exp_q[0] : '0);
            else n_pass++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL bp_drained: got %b required 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit ok;
        logic [RW-1:0] got;
        for (int r = 0; r < 2; r++) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < 4; i++)
                push_req(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         (i[0]) ? 4'd9 : 4'd0, 1'b1, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), acc);
            rsp_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                wait_rsp(got, ok);
                n_checks++;
                if (!ok || exp_q.size() == 0 || got !== exp_q[0])
                    $display("FAIL b2b_r%0d_%0d: got %h ok=%0d required %h", r, i, got, ok,
                             (exp_q.size() != 0) ? exp_q[0] : '0);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit acc;
        bit saw_valid;
        bit saw_ce;
        rsp_ready = 1'b1;
        push_req(8'd3, 8'd4, 4'd9, 1'b1, 1'b0, 1'b0, acc);
        push_req(8'd1, 8'd2, 4'd0, 1'b1, 1'b0, 1'b0, acc);
        push_req(8'd6, 8'd7, 4'd0, 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if ({CE, INP_VALID} !== 3'b100) $display("FAIL rst_mid_in_wait: got %b required 100", {CE, INP_VALID});
        else n_pass++;
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, rsp_valid, rsp_res, rsp_flags} !== '0)
            $display("FAIL rst_mid_outputs: got %h required 0",
                     {OPA, OPB, CMD, MODE, CIN, CE, INP_VALID, rsp_valid, rsp_res, rsp_flags});
        else n_pass++;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL rst_mid_req_ready: got %b required 1", req_ready);
        else n_pass++;
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        saw_valid = 1'b0;
        saw_ce = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            saw_valid |= rsp_valid;
            saw_ce |= CE;
        end
        n_checks++;
        if ({saw_valid, saw_ce} !== 2'b00)
            $display("FAIL rst_mid_dropped: got valid=%b ce=%b required 0 0", saw_valid, saw_ce);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_split();
        test_mul();
        test_compare_err();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
